alu_mdu_ctrl: RTL and testbench

Next-generation ALU controller. Combinationally decodes ALUOp/Funct3/Funct7 into an ALU operation code, with the encoding widened for full RV32I coverage. Adds an iterative RV32M multiply/divide unit (MDU) that stalls the pipeline until its result is ready. Sits in EX beside the ALU; the hazard unit consumes stall_o.

---
 rtl/alu_ctrl_pkg.sv | 47 ++++
 rtl/mdu_iter_core.sv | 151 +++++++++++++++
 rtl/alu_mdu_ctrl.sv | 81 ++++++++
 tb/tb_alu_mdu_ctrl.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_ctrl_pkg.sv
// Shared types for the ALU controller and its iterative RV32M unit.
package alu_ctrl_pkg;

  typedef enum logic [3:0] {
    OP_AND   = 4'b0000,
    OP_OR    = 4'b0001,
    OP_ADD   = 4'b0010,
    OP_SUB   = 4'b0011,
    OP_XOR   = 4'b0100,
    OP_SLL   = 4'b0101,
    OP_SRL   = 4'b0110,
    OP_SRA   = 4'b0111,
    OP_SLT   = 4'b1000,
    OP_SLTU  = 4'b1001,
    OP_EQ    = 4'b1010,
    OP_PASSB = 4'b1100
  } alu_op_e;

  typedef enum logic [1:0] {
    ALUOP_MEM    = 2'b00,
    ALUOP_BRANCH = 2'b01,
    ALUOP_ARITH  = 2'b10,
    ALUOP_JUMP   = 2'b11
  } aluop_e;

  localparam logic [6:0] FUNCT7_BASE   = 7'b0000000;
  localparam logic [6:0] FUNCT7_ALT    = 7'b0100000;
  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  typedef enum logic [2:0] {
    M_MUL    = 3'b000,
    M_MULH   = 3'b001,
    M_MULHSU = 3'b010,
    M_MULHU  = 3'b011,
    M_DIV    = 3'b100,
    M_DIVU   = 3'b101,
    M_REM    = 3'b110,
    M_REMU   = 3'b111
  } m_funct3_e;

  typedef enum logic [1:0] {
    MDU_IDLE = 2'b00,
    MDU_RUN  = 2'b01,
    MDU_DONE = 2'b10
  } mdu_state_e;

endpackage

// File: rtl/mdu_iter_core.sv
// Iterative RV32M engine: shift-add multiply / restoring divide on magnitudes.
// MDU_EARLY_OUT_EN: zero-operand multiplies and divide special cases skip the iterations.
module mdu_iter_core
  import alu_ctrl_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            start,
  input  logic            flush,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  output logic            done,
  output logic [XLEN-1:0] result,
  output mdu_state_e      state_o
);

  localparam int N     = XLEN / BITS_PER_CYCLE;
  localparam int CNT_W = $clog2(N + 1);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  mdu_state_e      state, state_n;
  logic [CNT_W-1:0] cnt;
  logic [XLEN-1:0] hi, lo, mcand;
  m_funct3_e       f3_q;
  logic            a_neg_q, res_neg_q, b_zero_q;

  logic            is_div, a_neg, b_neg, last;
  logic [XLEN-1:0] a_mag, b_mag;
  logic [XLEN-1:0] nhi, nlo, fin;
  logic [XLEN:0]   rem, sum;
  logic [2*XLEN-1:0] prod, prod_n;
  logic            early;
  logic [XLEN-1:0] early_res;

  assign is_div  = funct3[2];
  assign a_neg   = src_a[XLEN-1] && (funct3 inside {M_MUL, M_MULH, M_MULHSU, M_DIV, M_REM});
  assign b_neg   = src_b[XLEN-1] && (funct3 inside {M_MUL, M_MULH, M_DIV, M_REM});
  assign a_mag   = a_neg ? -src_a : src_a;
  assign b_mag   = b_neg ? -src_b : src_b;
  assign last    = (cnt == CNT_W'(N - 1));
  assign state_o = state;
  assign done    = (state == MDU_DONE) && !flush;

  // hi/lo hold {product} while multiplying, {remainder, quotient} while dividing.
  always_comb begin
    nhi = hi;
    nlo = lo;
    rem = '0;
    sum = '0;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      if (f3_q[2]) begin
        rem = {nhi, nlo[XLEN-1]};
        nlo = {nlo[XLEN-2:0], 1'b0};
        if (rem >= {1'b0, mcand}) begin
          rem    = rem - {1'b0, mcand};
          nlo[0] = 1'b1;
        end
        nhi = rem[XLEN-1:0];
      end else begin
        sum = {1'b0, nhi} + (nlo[0] ? {1'b0, mcand} : '0);
        nlo = {sum[0], nlo[XLEN-1:1]};
        nhi = sum[XLEN:1];
      end
    end
  end

  assign prod   = {nhi, nlo};
  assign prod_n = -prod;

  always_comb begin
    fin = '0;
    case (f3_q)
      M_MUL:                    fin = res_neg_q ? prod_n[XLEN-1:0] : nlo;
      M_MULH, M_MULHSU, M_MULHU: fin = res_neg_q ? prod_n[2*XLEN-1:XLEN] : nhi;
      M_DIV, M_DIVU:            fin = b_zero_q ? '1 : (res_neg_q ? -nlo : nlo);
      default:                  fin = a_neg_q ? -nhi : nhi;
    endcase
  end

  always_comb begin
    early     = 1'b0;
    early_res = '0;
`ifdef MDU_EARLY_OUT_EN
    if (is_div) begin
      if (src_b == '0) begin
        early     = 1'b1;
        early_res = funct3[1] ? src_a : '1;
      end else if (!funct3[0] && src_a == MIN_NEG && src_b == '1) begin
        early     = 1'b1;
        early_res = funct3[1] ? '0 : src_a;
      end
    end else if (src_a == '0 || src_b == '0) begin
      early = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= MDU_IDLE;
    else          state <= state_n;
  end

  always_comb begin
    state_n = state;
    if (flush) begin
      state_n = MDU_IDLE;
    end else begin
      case (state)
        MDU_IDLE: if (start) state_n = early ? MDU_DONE : MDU_RUN;
        MDU_RUN:  if (last)  state_n = MDU_DONE;
        default:             state_n = MDU_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt       <= '0;
      hi        <= '0;
      lo        <= '0;
      mcand     <= '0;
      f3_q      <= M_MUL;
      a_neg_q   <= 1'b0;
      res_neg_q <= 1'b0;
      b_zero_q  <= 1'b0;
      result    <= '0;
    end else if (!flush) begin
      if (state == MDU_IDLE && start) begin
        cnt       <= '0;
        hi        <= '0;
        lo        <= is_div ? a_mag : b_mag;
        mcand     <= is_div ? b_mag : a_mag;
        f3_q      <= m_funct3_e'(funct3);
        a_neg_q   <= a_neg;
        res_neg_q <= a_neg ^ b_neg;
        b_zero_q  <= (src_b == '0);
        if (early) result <= early_res;
      end else if (state == MDU_RUN) begin
        hi  <= nhi;
        lo  <= nlo;
        cnt <= cnt + CNT_W'(1);
        if (last) result <= fin;
      end
    end
  end

endmodule

// File: rtl/alu_mdu_ctrl.sv
// ALU operation decoder plus stall/select glue around the iterative MDU.
// MDU_EARLY_OUT_EN (in mdu_iter_core) shortens special-case M ops to one stall cycle.
module alu_mdu_ctrl
  import alu_ctrl_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int BITS_PER_CYCLE = 1,
  parameter int OP_W           = 4
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            valid_i,
  input  logic [1:0]      ALUOp,
  input  logic            RType,
  input  logic [6:0]      Funct7,
  input  logic [2:0]      Funct3,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  input  logic            flush_i,
  output logic [OP_W-1:0] Operation,
  output logic            md_sel_o,
  output logic            stall_o,
  output logic            md_done_o,
  output logic [XLEN-1:0] md_result
);

  alu_op_e    dec_op;
  mdu_state_e md_state;
  logic       md_req;

  always_comb begin
    dec_op = OP_ADD;
    case (aluop_e'(ALUOp))
      ALUOP_MEM:  dec_op = OP_ADD;
      ALUOP_JUMP: dec_op = OP_PASSB;
      ALUOP_BRANCH: begin
        case (Funct3)
          3'b000, 3'b001: dec_op = OP_EQ;
          3'b100, 3'b101: dec_op = OP_SLT;
          3'b110, 3'b111: dec_op = OP_SLTU;
          default:        dec_op = OP_ADD;
        endcase
      end
      default: begin
        case (Funct3)
          3'b000:  dec_op = (RType && Funct7 == FUNCT7_ALT) ? OP_SUB : OP_ADD;
          3'b001:  dec_op = OP_SLL;
          3'b010:  dec_op = OP_SLT;
          3'b011:  dec_op = OP_SLTU;
          3'b100:  dec_op = OP_XOR;
          3'b101:  dec_op = (Funct7 == FUNCT7_ALT) ? OP_SRA : OP_SRL;
          3'b110:  dec_op = OP_OR;
          default: dec_op = OP_AND;
        endcase
      end
    endcase
  end

  assign Operation = OP_W'(dec_op);
  assign md_req    = valid_i && (ALUOp == ALUOP_ARITH) && RType && (Funct7 == FUNCT7_MULDIV);
  assign md_sel_o  = md_req;
  // The EX instruction is held while stalled, so md_req stays up until DONE releases it.
  assign stall_o   = md_req && (md_state != MDU_DONE);

  mdu_iter_core #(
    .XLEN           (XLEN),
    .BITS_PER_CYCLE (BITS_PER_CYCLE)
  ) u_core (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (md_req),
    .flush   (flush_i),
    .funct3  (Funct3),
    .src_a   (src_a),
    .src_b   (src_b),
    .done    (md_done_o),
    .result  (md_result),
    .state_o (md_state)
  );

endmodule

// File: tb/tb_alu_mdu_ctrl.sv
// Self-checking bench for alu_mdu_ctrl: cycle-level reference model plus directed literals.
module tb_alu_mdu_ctrl;

  localparam int XLEN = 32;
  localparam int BPC  = 1;
  localparam int LAT  = XLEN / BPC + 1;
`ifdef MDU_EARLY_OUT_EN
  localparam int LAT_SP = 1;
`else
  localparam int LAT_SP = LAT;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        valid_i = 1'b0;
  logic [1:0]  ALUOp = 2'b00;
  logic        RType = 1'b0;
  logic [6:0]  Funct7 = 7'd0;
  logic [2:0]  Funct3 = 3'd0;
  logic [31:0] src_a = '0;
  logic [31:0] src_b = '0;
  logic        flush_i = 1'b0;
  logic [3:0]  Operation;
  logic        md_sel_o, stall_o, md_done_o;
  logic [31:0] md_result;

  int n_checks = 0;
  int n_errors = 0;

  alu_mdu_ctrl #(.XLEN(XLEN), .BITS_PER_CYCLE(BPC), .OP_W(4)) dut (
    .clk(clk), .reset_n(reset_n), .valid_i(valid_i), .ALUOp(ALUOp), .RType(RType),
    .Funct7(Funct7), .Funct3(Funct3), .src_a(src_a), .src_b(src_b), .flush_i(flush_i),
    .Operation(Operation), .md_sel_o(md_sel_o), .stall_o(stall_o),
    .md_done_o(md_done_o), .md_result(md_result)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [3:0] ref_op(input logic [1:0] aluop, input logic rt,
                                        input logic [6:0] f7, input logic [2:0] f3);
    logic [3:0] arith [8];
    arith = '{4'b0010, 4'b0101, 4'b1000, 4'b1001, 4'b0100, 4'b0110, 4'b0001, 4'b0000};
    if (aluop == 2'b00) return 4'b0010;
    if (aluop == 2'b11) return 4'b1100;
    if (aluop == 2'b01) begin
      if (f3 == 3'd0 || f3 == 3'd1) return 4'b1010;
      if (f3 == 3'd4 || f3 == 3'd5) return 4'b1000;
      if (f3 == 3'd6 || f3 == 3'd7) return 4'b1001;
      return 4'b0010;
    end
    if (f3 == 3'd0 && rt && f7 == 7'h20) return 4'b0011;
    if (f3 == 3'd5 && f7 == 7'h20) return 4'b0111;
    return arith[f3];
  endfunction

  function automatic logic [31:0] ref_m(input logic [2:0] f3, input logic [31:0] a,
                                        input logic [31:0] b);
    longint sa, sb, ub;
    logic [63:0] p, ua64, ub64;
    logic ovf;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ub = longint'({32'd0, b});
    ua64 = {32'd0, a};
    ub64 = {32'd0, b};
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (f3)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua64 * ub64; return p[63:32]; end
      3'd4: return (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'(sa / sb);
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: return (b == 0) ? a : ovf ? 32'd0 : 32'(sa % sb);
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int ref_lat(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    logic sp;
    if (f3[2]) sp = (b == 0) || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    else       sp = (a == 0) || (b == 0);
    return sp ? LAT_SP : LAT;
  endfunction

  function automatic logic cur_req();
    return valid_i && ALUOp == 2'b10 && RType && Funct7 == 7'h01;
  endfunction

  logic        m_active = 1'b0;
  int          m_k = 0;
  int          m_lat = LAT;
  logic [31:0] m_pend = '0;
  logic [31:0] exp_res = '0;

  // m_k is the cycle index of the current M op relative to its request cycle.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_active <= 1'b0;
      m_k      <= 0;
      exp_res  <= '0;
    end else if (flush_i) begin
      m_active <= 1'b0;
    end else if (!m_active) begin
      if (cur_req()) begin
        m_active <= 1'b1;
        m_k      <= 1;
        m_lat    <= ref_lat(Funct3, src_a, src_b);
        m_pend   <= ref_m(Funct3, src_a, src_b);
        if (ref_lat(Funct3, src_a, src_b) == 1) exp_res <= ref_m(Funct3, src_a, src_b);
      end
    end else if (m_k == m_lat) begin
      m_active <= 1'b0;
    end else begin
      m_k <= m_k + 1;
      if (m_k + 1 == m_lat) exp_res <= m_pend;
    end
  end

  always @(negedge clk) begin
    logic req, at_done;
    req = cur_req();
    at_done = m_active && m_k == m_lat;
    chk("md_sel", md_sel_o, req);
    if (!reset_n) begin
      chk("rst_stall", stall_o, req);
      chk("rst_done", md_done_o, 1'b0);
      chk("rst_result", md_result, 32'd0);
    end else begin
      chk("stall", stall_o, req && !at_done);
      chk("done", md_done_o, at_done && !flush_i);
      chk("result", md_result, exp_res);
      if (!req) chk("operation", Operation, ref_op(ALUOp, RType, Funct7, Funct3));
    end
  end

  // ---------------- drivers ----------------
  // All drivers start and end at posedge+1.
  task automatic set_instr(input logic [1:0] aluop, input logic rt, input logic [6:0] f7,
                           input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    valid_i = 1'b1; ALUOp = aluop; RType = rt; Funct7 = f7; Funct3 = f3;
    src_a = a; src_b = b; flush_i = 1'b0;
  endtask

  task automatic wait_done(input int flush_at, output int done_k, output logic [31:0] res);
    done_k = -1;
    res = '0;
    for (int k = 0; k < 200; k++) begin
      if (k == flush_at) flush_i = 1'b1;
      @(negedge clk);
      if (md_done_o) begin done_k = k; res = md_result; end
      @(posedge clk); #1;
      flush_i = 1'b0;
      if (done_k >= 0 || k == flush_at) break;
    end
    valid_i = 1'b0;
    if (done_k < 0 && flush_at < 0) begin
      n_checks++; n_errors++;
      $display("FAIL timeout: no md_done_o within 200 cycles, required one");
    end
  endtask

  task automatic m_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                      input int flush_at, output int done_k, output logic [31:0] res);
    set_instr(2'b10, 1'b1, 7'h01, f3, a, b);
    wait_done(flush_at, done_k, res);
  endtask

  task automatic m_lit(input string name, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp, input int lat);
    int dk;
    logic [31:0] r;
    m_op(f3, a, b, -1, dk, r);
    chk({name, "_res"}, r, exp);
    chk({name, "_lat"}, dk, lat);
  endtask

  task automatic dec_lit(input string name, input logic [1:0] aluop, input logic rt,
                         input logic [6:0] f7, input logic [2:0] f3, input logic [3:0] exp);
    set_instr(aluop, rt, f7, f3, 32'd1, 32'd2);
    @(negedge clk);
    chk(name, Operation, exp);
    @(posedge clk); #1;
    valid_i = 1'b0;
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int dk;
    logic [31:0] r;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk("reset_result", md_result, 32'd0);
    chk("reset_done", md_done_o, 1'b0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;

    dec_lit("dec_addi", 2'b10, 1'b0, 7'h20, 3'b000, 4'b0010);
    dec_lit("dec_sub",  2'b10, 1'b1, 7'h20, 3'b000, 4'b0011);
    dec_lit("dec_sltu", 2'b01, 1'b0, 7'h00, 3'b110, 4'b1001);
    dec_lit("dec_passb", 2'b11, 1'b0, 7'h00, 3'b000, 4'b1100);
    dec_lit("dec_srai", 2'b10, 1'b0, 7'h20, 3'b101, 4'b0111);

    m_lit("mul_7_m3", 3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, LAT);

    m_op(3'd4, 32'd1000, 32'd9, 10, dk, r);
    chk("flush_no_done", dk, -1);
    @(negedge clk);
    chk("flush_result_kept", md_result, 32'hFFFF_FFEB);
    @(posedge clk); #1;
    m_lit("div_after_flush", 3'd4, 32'd100, 32'd7, 32'd14, LAT);

    m_lit("mulhu_max", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, LAT);
    m_lit("divu_by0", 3'd5, 32'd100, 32'd0, 32'hFFFF_FFFF, LAT_SP);
    m_lit("rem_m7_2", 3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, LAT);
    m_lit("div_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, LAT_SP);
    m_lit("rem_ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, LAT_SP);
    m_lit("mulhsu_m1", 3'd2, 32'hFFFF_FFFF, 32'd16, 32'hFFFF_FFFF, LAT);

    // Reset in cycle 5 of a MULH; request stays held across reset.
    set_instr(2'b10, 1'b1, 7'h01, 3'd1, 32'h4000_0000, 32'h4000_0000);
    repeat (5) begin @(posedge clk); #1; end
    reset_n = 1'b0;
    @(negedge clk);
    chk("midop_rst_result", md_result, 32'd0);
    chk("midop_rst_stall", stall_o, 1'b1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset_n = 1'b1;
    wait_done(-1, dk, r);
    chk("mulh_restart_res", r, 32'h1000_0000);
    chk("mulh_restart_lat", dk, LAT);

    // Back-to-back: the DIVU is presented right in the IDLE cycle after DONE.
    m_lit("b2b_mul", 3'd0, 32'h1234, 32'h10, 32'h0001_2340, LAT);
    m_lit("b2b_divu", 3'd5, 32'd1000, 32'd3, 32'd333, LAT);

    for (int i = 0; i < 60; i++) begin
      logic [2:0] f3;
      logic [31:0] a, b;
      int fa;
      f3 = 3'($urandom_range(0, 7));
      a = pick();
      b = pick();
      if ($urandom_range(0, 2) == 0) begin
        fa = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 20)) : -1;
        m_op(f3, a, b, fa, dk, r);
        if (fa < 0) chk("rand_m_res", r, ref_m(f3, a, b));
      end else begin
        set_instr(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 1) == 1) ? 7'h20 : 7'($urandom_range(0, 127)),
                  f3, a, b);
        valid_i = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
        valid_i = 1'b0;
      end
    end

    repeat (3) begin @(posedge clk); #1; end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
